// File: rtl/router_fsm_param_if.sv
// Bus bundle between the router control FSM and its source / FIFO / register-block neighbours.
// The FSM sits on the slave modport; the surrounding datapath (or a bench) uses master.
interface router_fsm_param_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    // Handshake: the source holds pkt_valid and data_in stable while busy is high.
    // A header is accepted on any rising edge where detect_addr = 1 and pkt_valid = 1.
    // Payload bytes are written on every edge where wr_en_reg = 1.
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_rst;
    logic              parity_done;
    logic              low_pkt_valid;

    logic [ADDR_W-1:0] dest_sel;
    logic              detect_addr;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              wr_en_reg;
    logic              rst_int_reg;
    logic              busy;
    logic              timeout_err;
    logic [3:0]        state;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_rst, parity_done, low_pkt_valid,
        input  dest_sel, detect_addr, lfd_state, ld_state, laf_state, full_state,
        input  wr_en_reg, rst_int_reg, busy, timeout_err, state
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_rst, parity_done, low_pkt_valid,
        output dest_sel, detect_addr, lfd_state, ld_state, laf_state, full_state,
        output wr_en_reg, rst_int_reg, busy, timeout_err, state
    );
endinterface

// File: rtl/router_fsm_param.sv
// N-channel packet router control FSM with destination latch, soft-reset abort and drop of bad addresses.
// Optional wait-till-empty timeout is enabled by defining ROUTER_WAIT_TIMEOUT_EN.
module router_fsm_param #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 30
) (
    input logic            clk,
    input logic            rst,
    router_fsm_param_if.slave bus
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PKT           = 4'd8
    } state_t;

    if (NUM_CH < 2 || NUM_CH > 16 || (2 ** ADDR_W) < NUM_CH || WAIT_TIMEOUT < 1) begin : g_bad_params
        $error("router_fsm_param: illegal parameter combination");
    end

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] dest_sel_q;
    logic              detect_addr_q;
    logic              lfd_state_q;
    logic              ld_state_q;
    logic              laf_state_q;
    logic              full_state_q;
    logic              wr_en_reg_q;
    logic              rst_int_reg_q;
    logic              busy_q;

    logic hdr_in_range;
    logic hdr_empty;
    logic dest_empty;
    logic dest_soft_rst;
    logic wait_hit;

    // Channel lookups by loop so addresses beyond NUM_CH simply match nothing.
    always_comb begin
        hdr_in_range  = 1'b0;
        hdr_empty     = 1'b0;
        dest_empty    = 1'b0;
        dest_soft_rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.data_in == ADDR_W'(i)) begin
                hdr_in_range = 1'b1;
                hdr_empty    = bus.fifo_empty[i];
            end
            if (dest_sel_q == ADDR_W'(i)) begin
                dest_empty    = bus.fifo_empty[i];
                dest_soft_rst = bus.soft_rst[i];
            end
        end
    end

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_err_q;

    // wait_cnt_q counts completed WAIT_TILL_EMPTY cycles; the last allowed cycle is the hit.
    assign wait_hit = (state_q == WAIT_TILL_EMPTY) && (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q != WAIT_TILL_EMPTY)
                wait_cnt_q <= '0;
            else
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            timeout_err_q <= (state_q == WAIT_TILL_EMPTY) && (state_d == DROP_PKT);
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign wait_hit        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (!hdr_in_range)  state_d = DROP_PKT;
                    else if (hdr_empty) state_d = LOAD_FIRST_DATA;
                    else                state_d = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (bus.fifo_full) state_d = FIFO_FULL_STATE;
                else               state_d = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (dest_empty)    state_d = LOAD_FIRST_DATA;
                else if (wait_hit) state_d = DROP_PKT;
            end
            DROP_PKT: begin
                if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A read timeout on the selected channel aborts whatever packet is in flight.
        if (state_q != DECODE_ADDRESS && dest_soft_rst)
            state_d = DECODE_ADDRESS;
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= DECODE_ADDRESS;
            dest_sel_q    <= '0;
            detect_addr_q <= 1'b1;
            lfd_state_q   <= 1'b0;
            ld_state_q    <= 1'b0;
            laf_state_q   <= 1'b0;
            full_state_q  <= 1'b0;
            wr_en_reg_q   <= 1'b0;
            rst_int_reg_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && bus.pkt_valid)
                dest_sel_q <= bus.data_in;
            detect_addr_q <= (state_d == DECODE_ADDRESS);
            lfd_state_q   <= (state_d == LOAD_FIRST_DATA);
            ld_state_q    <= (state_d == LOAD_DATA);
            laf_state_q   <= (state_d == LOAD_AFTER_FULL);
            full_state_q  <= (state_d == FIFO_FULL_STATE);
            wr_en_reg_q   <= (state_d == LOAD_DATA) || (state_d == LOAD_AFTER_FULL) ||
                             (state_d == LOAD_PARITY);
            rst_int_reg_q <= (state_d == CHECK_PARITY_ERROR);
            busy_q        <= (state_d == LOAD_FIRST_DATA) || (state_d == FIFO_FULL_STATE) ||
                             (state_d == LOAD_AFTER_FULL) || (state_d == LOAD_PARITY) ||
                             (state_d == CHECK_PARITY_ERROR) || (state_d == WAIT_TILL_EMPTY);
        end
    end

    assign bus.dest_sel    = dest_sel_q;
    assign bus.detect_addr = detect_addr_q;
    assign bus.lfd_state   = lfd_state_q;
    assign bus.ld_state    = ld_state_q;
    assign bus.laf_state   = laf_state_q;
    assign bus.full_state  = full_state_q;
    assign bus.wr_en_reg   = wr_en_reg_q;
    assign bus.rst_int_reg = rst_int_reg_q;
    assign bus.busy        = busy_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_router_fsm_param.sv
// Directed bench for router_fsm_param: normal packet, full stalls, wait, drop, soft-reset and async reset.
// Output vectors are {detect_addr, lfd, ld, laf, full, wr_en_reg, rst_int_reg, busy}.
module tb_router_fsm_param;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;

    localparam logic [7:0] O_DEC = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LAF = 8'b0001_0101;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;
    localparam logic [7:0] O_DRP = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    router_fsm_param_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

    router_fsm_param #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.wr_en_reg, bus.rst_int_reg, bus.busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = '0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = '1;
        bus.soft_rst      = '0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs(), O_DEC); end
        checks++; if (bus.dest_sel !== 2'd0) begin errors++; $display("FAIL reset_dest got=%0d exp=0", bus.dest_sel); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got=%b exp=0", bus.timeout_err); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL idle_dec got=%b exp=%b", outs(), O_DEC); end
    endtask

    task automatic test_normal();
        bus.fifo_empty = 3'b111; bus.data_in = 2'd1; bus.pkt_valid = 1'b1;
        step();
        checks++; if (outs() !== O_LFD) begin errors++; $display("FAIL norm_lfd got=%b exp=%b", outs(), O_LFD); end
        checks++; if (bus.dest_sel !== 2'd1) begin errors++; $display("FAIL norm_dest got=%0d exp=1", bus.dest_sel); end
        step();
        checks++; if (outs() !== O_LD) begin errors++; $display("FAIL norm_ld got=%b exp=%b", outs(), O_LD); end
        step();
        checks++; if (outs() !== O_LD) begin errors++; $display("FAIL norm_ld_hold got=%b exp=%b", outs(), O_LD); end
        bus.pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_LP) begin errors++; $display("FAIL norm_lp got=%b exp=%b", outs(), O_LP); end
        step();
        checks++; if (outs() !== O_CPE) begin errors++; $display("FAIL norm_cpe got=%b exp=%b", outs(), O_CPE); end
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL norm_dec got=%b exp=%b", outs(), O_DEC); end
        checks++; if (bus.dest_sel !== 2'd1) begin errors++; $display("FAIL norm_dest_hold got=%0d exp=1", bus.dest_sel); end
    endtask

    task automatic test_fifo_full();
        bus.data_in = 2'd0; bus.pkt_valid = 1'b1;
        step(); step();
        checks++; if (outs() !== O_LD) begin errors++; $display("FAIL full_ld got=%b exp=%b", outs(), O_LD); end
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (outs() !== O_FFS) begin errors++; $display("FAIL full_ffs%0d got=%b exp=%b", i, outs(), O_FFS); end
        end
        bus.fifo_full = 1'b0;
        step();
        checks++; if (outs() !== O_LAF) begin errors++; $display("FAIL full_laf got=%b exp=%b", outs(), O_LAF); end
        bus.low_pkt_valid = 1'b1; bus.pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_LP) begin errors++; $display("FAIL full_laf_lp got=%b exp=%b", outs(), O_LP); end
        bus.low_pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_CPE) begin errors++; $display("FAIL full_cpe got=%b exp=%b", outs(), O_CPE); end
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL full_dec got=%b exp=%b", outs(), O_DEC); end
        // Second packet: LAF back to LD, CPE into FFS, then LAF exits on parity_done.
        bus.pkt_valid = 1'b1;
        step(); step();
        bus.fifo_full = 1'b1;
        step();
        bus.fifo_full = 1'b0;
        step();
        checks++; if (outs() !== O_LAF) begin errors++; $display("FAIL full2_laf got=%b exp=%b", outs(), O_LAF); end
        step();
        checks++; if (outs() !== O_LD) begin errors++; $display("FAIL full2_laf_ld got=%b exp=%b", outs(), O_LD); end
        bus.pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_LP) begin errors++; $display("FAIL full2_lp got=%b exp=%b", outs(), O_LP); end
        bus.fifo_full = 1'b1;
        step();
        checks++; if (outs() !== O_CPE) begin errors++; $display("FAIL full2_cpe got=%b exp=%b", outs(), O_CPE); end
        step();
        checks++; if (outs() !== O_FFS) begin errors++; $display("FAIL full2_cpe_ffs got=%b exp=%b", outs(), O_FFS); end
        bus.fifo_full = 1'b0;
        step();
        checks++; if (outs() !== O_LAF) begin errors++; $display("FAIL full2_laf2 got=%b exp=%b", outs(), O_LAF); end
        bus.parity_done = 1'b1;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL full2_pdone_dec got=%b exp=%b", outs(), O_DEC); end
        bus.parity_done = 1'b0;
    endtask

    task automatic test_wait();
        bus.fifo_empty = 3'b011; bus.data_in = 2'd2; bus.pkt_valid = 1'b1;
        step();
        checks++; if (outs() !== O_WTE) begin errors++; $display("FAIL wait_wte got=%b exp=%b", outs(), O_WTE); end
        checks++; if (bus.dest_sel !== 2'd2) begin errors++; $display("FAIL wait_dest got=%0d exp=2", bus.dest_sel); end
        bus.data_in = 2'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (outs() !== O_WTE) begin errors++; $display("FAIL wait_hold%0d got=%b exp=%b", i, outs(), O_WTE); end
        end
        bus.fifo_empty = 3'b111;
        step();
        checks++; if (outs() !== O_LFD) begin errors++; $display("FAIL wait_lfd got=%b exp=%b", outs(), O_LFD); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wait_terr got=%b exp=0", bus.timeout_err); end
        step();
        bus.soft_rst = 3'b100; bus.pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL wait_srst_dec got=%b exp=%b", outs(), O_DEC); end
        bus.soft_rst = '0;
    endtask

    task automatic test_drop();
        bus.fifo_empty = 3'b111; bus.data_in = 2'd3; bus.pkt_valid = 1'b1;
        step();
        checks++; if (outs() !== O_DRP) begin errors++; $display("FAIL drop_enter got=%b exp=%b", outs(), O_DRP); end
        checks++; if (bus.dest_sel !== 2'd3) begin errors++; $display("FAIL drop_dest got=%0d exp=3", bus.dest_sel); end
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 2'(i);
            step();
            checks++; if (outs() !== O_DRP) begin errors++; $display("FAIL drop_hold%0d got=%b exp=%b", i, outs(), O_DRP); end
        end
        bus.pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL drop_dec got=%b exp=%b", outs(), O_DEC); end
    endtask

    task automatic test_soft_rst();
        bus.data_in = 2'd0; bus.pkt_valid = 1'b1; bus.soft_rst = 3'b001;
        step();
        checks++; if (outs() !== O_LFD) begin errors++; $display("FAIL srst_dec_ignored got=%b exp=%b", outs(), O_LFD); end
        bus.soft_rst = '0;
        step();
        bus.soft_rst = 3'b010;
        step();
        checks++; if (outs() !== O_LD) begin errors++; $display("FAIL srst_other_ch got=%b exp=%b", outs(), O_LD); end
        bus.soft_rst = 3'b001;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL srst_abort got=%b exp=%b", outs(), O_DEC); end
        bus.soft_rst = '0; bus.pkt_valid = 1'b0;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL srst_idle got=%b exp=%b", outs(), O_DEC); end
    endtask

    task automatic test_async_rst();
        bus.data_in = 2'd1; bus.pkt_valid = 1'b1;
        step(); step();
        bus.fifo_full = 1'b1;
        step();
        checks++; if (outs() !== O_FFS) begin errors++; $display("FAIL arst_pre_ffs got=%b exp=%b", outs(), O_FFS); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL arst_outs got=%b exp=%b", outs(), O_DEC); end
        checks++; if (bus.dest_sel !== 2'd0) begin errors++; $display("FAIL arst_dest got=%0d exp=0", bus.dest_sel); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL arst_after got=%b exp=%b", outs(), O_DEC); end
    endtask

`ifdef ROUTER_WAIT_TIMEOUT_EN
    task automatic test_timeout();
        bus.fifo_empty = 3'b011; bus.data_in = 2'd2; bus.pkt_valid = 1'b1;
        step();
        for (int i = 0; i < 29; i++) begin
            step();
            checks++; if (outs() !== O_WTE || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got=%b/%b exp=%b/0", i, outs(), bus.timeout_err, O_WTE); end
        end
        step();
        checks++; if (outs() !== O_DRP) begin errors++; $display("FAIL tmo_drop got=%b exp=%b", outs(), O_DRP); end
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse got=%b exp=1", bus.timeout_err); end
        step();
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_single got=%b exp=0", bus.timeout_err); end
        bus.pkt_valid = 1'b0;
        step();
        bus.pkt_valid = 1'b1;
        step();
        for (int i = 0; i < 29; i++) step();
        checks++; if (outs() !== O_WTE) begin errors++; $display("FAIL tmo2_wait got=%b exp=%b", outs(), O_WTE); end
        bus.fifo_empty = 3'b111;
        step();
        checks++; if (outs() !== O_LFD) begin errors++; $display("FAIL tmo2_lfd got=%b exp=%b", outs(), O_LFD); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo2_noerr got=%b exp=0", bus.timeout_err); end
        bus.pkt_valid = 1'b0;
        step(); step(); step(); step();
        checks++; if (outs() !== O_DEC) begin errors++; $display("FAIL tmo2_dec got=%b exp=%b", outs(), O_DEC); end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_fifo_full();
        test_wait();
        test_drop();
        test_soft_rst();
        test_async_rst();
`ifdef ROUTER_WAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
